// File: rtl/shift_sub_div_64_if.sv
// Command/result bundle for the sequential signed divider.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface shift_sub_div_64_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shift_sub_div_64.sv
// Signed restoring divider: one quotient bit per clock on magnitudes, sign fix-up at the end.
// Truncating semantics (remainder follows dividend sign); b == 0 returns q = -1, r = a.
module shift_sub_div_64 #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_sub_div_64_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // dividend magnitude, becomes quotient magnitude as bits shift in
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_diff;
  logic             take;
  logic             accept;

  assign accept = bus.in_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == LAST_ITER) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.out_valid   = out_valid_q;
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
    dbg_state       = state_q;
  end

  // P < |b| <= 2^(WIDTH-1) keeps P' - |b| within WIDTH bits, so the top bit of the
  // WIDTH+1 bit difference is exactly the borrow.
  always_comb begin
    p_shift = {p_q, a_q[WIDTH-1]};
    p_diff  = p_shift - {1'b0, b_q};
    take    = ~p_diff[WIDTH];
  end

  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          b_d      = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
          sign_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r_d = bus.dividend[WIDTH-1];
          p_d      = '0;
          cnt_d    = '0;
          if (bus.divisor == '0) begin
            quot_d      = '1;
            rem_d       = bus.dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      CALC: begin
        p_d   = take ? p_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], take};
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        quot_d      = sign_q_q ? -a_q : a_q;
        rem_d       = sign_r_q ? -p_q : p_q;
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_shift_sub_div_64.sv
// Directed bench for shift_sub_div_64: vector table plus backpressure and mid-operation reset sequences.
module tb_shift_sub_div_64;
  localparam int W   = 64;
  localparam int LAT = W + 1;
  localparam int NV  = 11;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  shift_sub_div_64_if #(.WIDTH(W)) bus ();

  shift_sub_div_64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t         vecs [NV];
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mul_model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) if (y[i]) p = p + (x << i);
    return p;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    @(negedge clk);
    check({name, "_in_ready_idle"}, W'(bus.in_ready), W'(1));
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string name);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_out_valid_seen"}, W'(bus.out_valid), W'(1));
    check({name, "_latency"}, W'(lat), W'(exp_lat));
    check({name, "_in_ready_busy"}, W'(busy_ok && (bus.in_ready === 1'b0)), W'(1));
  endtask

  task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic dbz, input string name);
    logic [W-1:0] eq, er;
    eq = exp_q.pop_front();
    er = exp_q.pop_front();
    check({name, "_quotient"}, bus.quotient, eq);
    check({name, "_remainder"}, bus.remainder, er);
    check({name, "_div_by_zero"}, W'(bus.div_by_zero), W'(dbz));
    if (!dbz) check({name, "_q*b+r"}, mul_model(bus.quotient, b) + bus.remainder, a);
  endtask

  task automatic drain(input logic [W-1:0] held_q, input logic [W-1:0] held_r, input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_drain_out_valid"}, W'(bus.out_valid), W'(0));
    check({name, "_drain_in_ready"}, W'(bus.in_ready), W'(1));
    check({name, "_drain_dbz"}, W'(bus.div_by_zero), W'(0));
    check({name, "_drain_q_held"}, bus.quotient, held_q);
    check({name, "_drain_r_held"}, bus.remainder, held_r);
  endtask

  initial begin
    vecs[0]  = '{a: 64'd100, b: 64'd7, q: 64'd14, r: 64'd2, dbz: 1'b0};
    vecs[1]  = '{a: -64'sd100, b: 64'd7, q: -64'sd14, r: -64'sd2, dbz: 1'b0};
    vecs[2]  = '{a: 64'd100, b: -64'sd7, q: -64'sd14, r: 64'd2, dbz: 1'b0};
    vecs[3]  = '{a: -64'sd100, b: -64'sd7, q: 64'd14, r: -64'sd2, dbz: 1'b0};
    vecs[4]  = '{a: 64'h8000_0000_0000_0000, b: 64'hFFFF_FFFF_FFFF_FFFF,
                 q: 64'h8000_0000_0000_0000, r: 64'd0, dbz: 1'b0};
    vecs[5]  = '{a: 64'd5, b: 64'd9, q: 64'd0, r: 64'd5, dbz: 1'b0};
    vecs[6]  = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd0, dbz: 1'b0};
    vecs[7]  = '{a: 64'd55, b: 64'd0, q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd55, dbz: 1'b1};
    vecs[8]  = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, q: 64'd1, r: 64'd0, dbz: 1'b0};
    vecs[9]  = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h8000_0000_0000_0000,
                 q: 64'd0, r: 64'h7FFF_FFFF_FFFF_FFFF, dbz: 1'b0};
    vecs[10] = '{a: -64'sd7, b: 64'd0, q: 64'hFFFF_FFFF_FFFF_FFFF, r: -64'sd7, dbz: 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", W'(dbg_state), W'(0));
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_quotient", bus.quotient, W'(0));
    check("reset_remainder", bus.remainder, W'(0));
    check("reset_dbz", W'(bus.div_by_zero), W'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      string name;
      name = $sformatf("vec%0d", i);
      exp_q.push_back(vecs[i].q);
      exp_q.push_back(vecs[i].r);
      send(vecs[i].a, vecs[i].b, name);
      wait_result(vecs[i].dbz ? 0 : LAT, name);
      check_result(vecs[i].a, vecs[i].b, vecs[i].dbz, name);
      drain(vecs[i].q, vecs[i].r, name);
    end

    // backpressure: result must hold for 10 cycles, stray commands ignored
    exp_q.push_back(-64'sd30);
    exp_q.push_back(64'd3);
    send(64'd123, -64'sd4, "bp");
    wait_result(LAT, "bp");
    check_result(64'd123, -64'sd4, 1'b0, "bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.dividend = 64'd7;
        bus.divisor  = 64'd0;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", c),
            {bus.quotient[59:0], bus.out_valid, bus.in_ready, bus.div_by_zero, 1'b0},
            {64'hFFFF_FFFF_FFFF_FFE2 << 4 | 64'h8});
      check($sformatf("bp_hold_r%0d", c), bus.remainder, 64'd3);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain(-64'sd30, 64'd3, "bp");

    exp_q.push_back(64'd100);
    exp_q.push_back(64'd0);
    send(64'd1000, 64'd10, "b2b");
    wait_result(LAT, "b2b");
    check_result(64'd1000, 64'd10, 1'b0, "b2b");
    drain(64'd100, 64'd0, "b2b");

    // reset during iteration 20 of a fresh command
    send(64'd1000, 64'd10, "rst_mid");
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_state", W'(dbg_state), W'(0));
    check("rst_mid_in_ready", W'(bus.in_ready), W'(1));
    check("rst_mid_out_valid", W'(bus.out_valid), W'(0));
    check("rst_mid_quotient", bus.quotient, W'(0));
    check("rst_mid_remainder", bus.remainder, W'(0));

    exp_q.push_back(64'd9);
    exp_q.push_back(64'd0);
    send(64'd81, 64'd9, "after_rst");
    wait_result(LAT, "after_rst");
    check_result(64'd81, 64'd9, 1'b0, "after_rst");
    drain(64'd9, 64'd0, "after_rst");

    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
